// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and models mult/div latency with a busy counter.
// Results are computed at issue, held as pending, and committed to HI/LO when the counter expires.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_data1,
   input  logic [31:0] E_data2,
   input  logic [3:0]  E_mdu_op,
   output logic        E_start,
   output logic        E_busy,
   output logic [31:0] E_hi,
   output logic [31:0] E_lo,
   output logic [31:0] E_mdu_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e           state;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      hi_q, hi_nxt;
   logic [31:0]      lo_q, lo_nxt;
   logic [31:0]      pend_hi, pend_hi_nxt;
   logic [31:0]      pend_lo, pend_lo_nxt;
   logic             pend_vld, pend_vld_nxt;

   // 64-bit product; truncating a 64x64 product of extended operands gives the exact result.
   function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
      logic signed [63:0] xa;
      logic signed [63:0] xb;
      logic signed [63:0] prod;
      xa   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      xb   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
      prod = xa * xb;
      return prod;
   endfunction

   // Returns {remainder, quotient}. Signed divide works on magnitudes so that the
   // most-negative / -1 case wraps to 0x80000000 instead of overflowing.
   function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
      logic        neg_a;
      logic        neg_b;
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] uq;
      logic [31:0] ur;
      logic [31:0] q;
      logic [31:0] r;
      neg_a = is_signed & a[31];
      neg_b = is_signed & b[31];
      mag_a = neg_a ? (~a + 32'd1) : a;
      mag_b = neg_b ? (~b + 32'd1) : b;
      if (mag_b == 32'd0) begin
         mag_b = 32'd1;
      end
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
      q  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      r  = neg_a ? (~ur + 32'd1) : ur;
      return {r, q};
   endfunction

   assign E_busy = (cnt != '0);
   assign state  = E_busy ? BUSY : IDLE;
   assign E_hi   = hi_q;
   assign E_lo   = lo_q;

   always_comb begin
      E_start = 1'b0;
      if (!E_busy && (E_mdu_op >= OP_MULT) && (E_mdu_op <= OP_DIVU)) begin
         E_start = 1'b1;
      end
   end

   always_comb begin
      E_mdu_out = 32'd0;
      case (E_mdu_op)
         OP_MFHI: E_mdu_out = hi_q;
         OP_MFLO: E_mdu_out = lo_q;
         default: E_mdu_out = 32'd0;
      endcase
   end

   always_comb begin
      cnt_nxt      = cnt;
      hi_nxt       = hi_q;
      lo_nxt       = lo_q;
      pend_hi_nxt  = pend_hi;
      pend_lo_nxt  = pend_lo;
      pend_vld_nxt = pend_vld;
      case (state)
         IDLE: begin
            case (E_mdu_op)
               OP_MULT, OP_MULTU: begin
                  {pend_hi_nxt, pend_lo_nxt} = mul_res(E_data1, E_data2, E_mdu_op == OP_MULT);
                  pend_vld_nxt = 1'b1;
                  cnt_nxt      = MULT_LOAD;
               end
               OP_DIV, OP_DIVU: begin
                  {pend_hi_nxt, pend_lo_nxt} = div_res(E_data1, E_data2, E_mdu_op == OP_DIV);
                  // A zero divisor still occupies the unit but leaves HI/LO untouched.
                  pend_vld_nxt = (E_data2 != 32'd0);
                  cnt_nxt      = DIV_LOAD;
               end
               OP_MTHI: hi_nxt = E_data1;
               OP_MTLO: lo_nxt = E_data1;
               default: ;
            endcase
         end
         BUSY: begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               pend_vld_nxt = 1'b0;
               if (pend_vld) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         pend_hi  <= 32'd0;
         pend_lo  <= 32'd0;
         pend_vld <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         pend_hi  <= pend_hi_nxt;
         pend_lo  <= pend_lo_nxt;
         pend_vld <= pend_vld_nxt;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO are queued at issue and checked when busy drops.
module tb_e_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] E_data1;
   logic [31:0] E_data2;
   logic [3:0]  E_mdu_op;
   logic        E_start;
   logic        E_busy;
   logic [31:0] E_hi;
   logic [31:0] E_lo;
   logic [31:0] E_mdu_out;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .E_data1   (E_data1),
      .E_data2   (E_data2),
      .E_mdu_op  (E_mdu_op),
      .E_start   (E_start),
      .E_busy    (E_busy),
      .E_hi      (E_hi),
      .E_lo      (E_lo),
      .E_mdu_out (E_mdu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          n_checks;
   int          n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference model in 64-bit integer arithmetic; updates the model HI/LO and queues them.
   task automatic expect_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd3: if (b != 32'd0) begin
                  p = sa / sb; m_lo = p[31:0];
                  p = sa % sb; m_hi = p[31:0];
               end
         4'd4: if (b != 32'd0) begin
                  p = ua / ub; m_lo = p[31:0];
                  p = ua % ub; m_hi = p[31:0];
               end
         default: ;
      endcase
      sb_q.push_back({m_hi, m_lo});
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      E_mdu_op = op;
      E_data1  = a;
      E_data2  = b;
      #1;
   endtask

   task automatic start_op(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      drive(op, a, b);
      check({tag, "_start"}, {31'd0, E_start}, 32'd1);
      expect_op(op, a, b);
      @(posedge clk);
      #1;
      E_mdu_op = 4'd0;
   endtask

   task automatic move(input logic [3:0] op, input logic [31:0] a);
      drive(op, a, 32'd0);
      if (op == 4'd5) m_hi = a;
      else m_lo = a;
      @(posedge clk);
      #1;
      E_mdu_op = 4'd0;
   endtask

   // Counts remaining busy cycles (bounded), then pops the scoreboard and compares HI/LO.
   task automatic wait_done(input string tag, input int n);
      int          cyc;
      logic [63:0] exp;
      cyc = 0;
      while (E_busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(posedge clk);
         #1;
      end
      check({tag, "_busy_cycles"}, cyc, n);
      check({tag, "_sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check({tag, "_hi"}, E_hi, exp[63:32]);
         check({tag, "_lo"}, E_lo, exp[31:0]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
      reset    = 1'b0;
      E_data1  = 32'd0;
      E_data2  = 32'd0;
      E_mdu_op = 4'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_busy", {31'd0, E_busy}, 32'd0);
      check("rst_hi", E_hi, 32'd0);
      check("rst_lo", E_lo, 32'd0);
      check("rst_out", E_mdu_out, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // reset while a mult is in flight
      move(4'd5, 32'h55);
      move(4'd6, 32'h66);
      check("pre_rst_hi", E_hi, 32'h55);
      start_op("rst_mult", 4'd1, 32'd3, 32'd4);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, E_busy}, 32'd0);
      check("midrst_hi", E_hi, 32'd0);
      check("midrst_lo", E_lo, 32'd0);
      sb_q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("postrst_busy", {31'd0, E_busy}, 32'd0);
      check("postrst_hi", E_hi, 32'd0);
      check("postrst_lo", E_lo, 32'd0);

      // directed multiplies and divides with literal expectations
      start_op("mult_m1x2", 4'd1, 32'hFFFF_FFFF, 32'd2);
      wait_done("mult_m1x2", MULT_N);
      check("mult_m1x2_hi_lit", E_hi, 32'hFFFF_FFFF);
      check("mult_m1x2_lo_lit", E_lo, 32'hFFFF_FFFE);
      start_op("multu_m1x2", 4'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu_m1x2", MULT_N);
      check("multu_hi_lit", E_hi, 32'h0000_0001);
      check("multu_lo_lit", E_lo, 32'hFFFF_FFFE);
      start_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7_2", DIV_N);
      check("div_m7_2_lo_lit", E_lo, 32'hFFFF_FFFD);
      check("div_m7_2_hi_lit", E_hi, 32'hFFFF_FFFF);
      start_op("divu_7_2", 4'd4, 32'd7, 32'd2);
      wait_done("divu_7_2", DIV_N);
      check("divu_lo_lit", E_lo, 32'd3);
      check("divu_hi_lit", E_hi, 32'd1);
      start_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", DIV_N);
      check("div_ovf_lo_lit", E_lo, 32'h8000_0000);
      check("div_ovf_hi_lit", E_hi, 32'd0);

      // divide by zero keeps HI/LO
      move(4'd5, 32'h11);
      move(4'd6, 32'h22);
      start_op("div_by0", 4'd3, 32'd5, 32'd0);
      wait_done("div_by0", DIV_N);
      check("div_by0_hi_lit", E_hi, 32'h11);
      check("div_by0_lo_lit", E_lo, 32'h22);

      // register moves and reads; ops 0 and 9-15 read as zero
      move(4'd5, 32'hDEAD_BEEF);
      move(4'd6, 32'h0000_1234);
      drive(4'd7, 32'd0, 32'd0);
      check("mfhi", E_mdu_out, 32'hDEAD_BEEF);
      drive(4'd8, 32'd0, 32'd0);
      check("mflo", E_mdu_out, 32'h0000_1234);
      drive(4'd12, 32'h77, 32'h77);
      check("op12_out", E_mdu_out, 32'd0);
      check("op12_start", {31'd0, E_start}, 32'd0);
      @(posedge clk);
      #1;
      check("op12_hi_kept", E_hi, 32'hDEAD_BEEF);
      E_mdu_op = 4'd0;

      // ops issued while busy are ignored
      start_op("ign", 4'd1, 32'd6, 32'd7);
      drive(4'd1, 32'd100, 32'd100);
      check("ign_mult_start", {31'd0, E_start}, 32'd0);
      @(posedge clk);
      drive(4'd5, 32'hABCD, 32'd0);
      check("ign_mthi_start", {31'd0, E_start}, 32'd0);
      @(posedge clk);
      #1;
      E_mdu_op = 4'd0;
      wait_done("ign", MULT_N - 2);

      // back-to-back issue on the first idle cycle
      start_op("b2b_a", 4'd2, 32'h0001_0000, 32'h0001_0000);
      wait_done("b2b_a", MULT_N);
      start_op("b2b_b", 4'd1, 32'hFFFF_FFFD, 32'd9);
      check("b2b_busy_again", {31'd0, E_busy}, 32'd1);
      check("b2b_hi_prev", E_hi, 32'd1);
      wait_done("b2b_b", MULT_N);

      // random operands through the model
      for (int i = 0; i < 8; i++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 4'($urandom_range(1, 4));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         start_op("rnd", op, a, b);
         wait_done("rnd", (op <= 4'd2) ? MULT_N : DIV_N);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
